// File: rtl/stim_check_harness.sv
// Deterministic stimulus generator and latency-matched response checker for a
// two-input, one-output datapath; doubles as a synthesisable BIST wrapper.
module stim_check_harness #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned MODE        = 2,
    parameter logic [15:0] SEED        = 16'h00A5,
    parameter int unsigned LATENCY     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] stim_a,
    output logic [WIDTH-1:0] stim_b,
    output logic             stim_valid,
    input  logic [WIDTH-1:0] dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam logic [15:0]      LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [WIDTH-1:0] SEED_W     = SEED[WIDTH-1:0];
    localparam logic [3:0]       DRAIN_LAST = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    state_e           state_q;
    logic [15:0]      cnt_q;
    logic [15:0]      vec_idx_q;
    logic [3:0]       drain_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [15:0]      err_q;
    logic [15:0]      err_d;
    logic [15:0]      first_err_q;

    logic [WIDTH-1:0] exp_now;
    logic             cmp_valid;
    logic [WIDTH-1:0] cmp_exp;
    logic [15:0]      cmp_idx;
    logic             mismatch;
    logic             run_clear;

    always_comb begin
        exp_now = a_q + b_q;
        case (MODE)
            0:       exp_now = a_q & b_q;
            1:       exp_now = a_q | b_q;
            2:       exp_now = a_q ^ b_q;
            default: exp_now = a_q + b_q;
        endcase
    end

    // The expected value travels alongside the DUT so the compare sees the
    // vector that produced the current dut_y.
    if (LATENCY == 0) begin : g_nodelay
        assign cmp_valid = valid_q;
        assign cmp_exp   = exp_now;
        assign cmp_idx   = vec_idx_q;
    end else begin : g_delay
        logic [WIDTH-1:0] exp_pipe_q [LATENCY];
        logic [15:0]      idx_pipe_q [LATENCY];
        logic [LATENCY-1:0] vld_pipe_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < LATENCY; i++) begin
                    exp_pipe_q[i] <= '0;
                    idx_pipe_q[i] <= '0;
                end
                vld_pipe_q <= '0;
            end else begin
                exp_pipe_q[0] <= exp_now;
                idx_pipe_q[0] <= vec_idx_q;
                vld_pipe_q[0] <= valid_q;
                for (int i = 1; i < LATENCY; i++) begin
                    exp_pipe_q[i] <= exp_pipe_q[i-1];
                    idx_pipe_q[i] <= idx_pipe_q[i-1];
                    vld_pipe_q[i] <= vld_pipe_q[i-1];
                end
            end
        end

        assign cmp_valid = vld_pipe_q[LATENCY-1];
        assign cmp_exp   = exp_pipe_q[LATENCY-1];
        assign cmp_idx   = idx_pipe_q[LATENCY-1];
    end

    assign mismatch = cmp_valid && (dut_y != cmp_exp);

    // Counts are wiped on the first RUN cycle, so the previous run's totals
    // stay visible for the whole cycle in which done is high.
    assign run_clear = (state_q == RUN) && (cnt_q == 16'd0);

    always_comb begin
        err_d = err_q;
        if (run_clear) begin
            err_d = 16'd0;
        end else if (mismatch && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vec_idx_q   <= '0;
            drain_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            first_err_q <= '0;
        end else begin
            busy_q  <= (state_q == RUN) || (state_q == DRAIN);
            done_q  <= (state_q == DONE);
            pass_q  <= (state_q == DONE) && (err_d == 16'd0);
            err_q   <= err_d;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;

            if (run_clear) begin
                first_err_q <= '0;
            end else if (mismatch && (err_q == 16'd0)) begin
                first_err_q <= cmp_idx;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    valid_q   <= 1'b1;
                    a_q       <= cnt_q[WIDTH-1:0];
                    b_q       <= cnt_q[WIDTH-1:0] ^ SEED_W;
                    vec_idx_q <= cnt_q;
                    cnt_q     <= cnt_q + 16'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_q <= (LATENCY == 0) ? DONE : DRAIN;
                        drain_q <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim_a        = a_q;
    assign stim_b        = b_q;
    assign stim_valid    = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_stim_check_harness.sv
// Directed bench for stim_check_harness: XOR/latency-1, ADD/latency-2 wrap and
// latency-0 back-to-back restart configurations, each against a small DUT model.
module tb_stim_check_harness;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic startX = 1'b0;
    logic startA = 1'b0;
    logic startZ = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  aX, bX, yX;
    logic        vX, busyX, doneX, passX;
    logic [15:0] errX, firstX;
    logic        faultX = 1'b0;

    logic [7:0]  aA, bA, yA, s1A;
    logic        vA, busyA, doneA, passA;
    logic [15:0] errA, firstA;
    logic        carryBug = 1'b0;
    logic [8:0]  sumA;

    logic [7:0]  aZ, bZ, yZ;
    logic        vZ, busyZ, doneZ, passZ;
    logic [15:0] errZ, firstZ;
    logic [3:0]  badVec = 4'b0000;

    int tests  = 0;
    int errors = 0;

    stim_check_harness #(.WIDTH(8), .NUM_VECTORS(4), .MODE(2), .SEED(16'h00A5), .LATENCY(1)) u_xor (
        .clk(clk), .rst(rst), .start(startX), .stim_a(aX), .stim_b(bX), .stim_valid(vX),
        .dut_y(yX), .busy(busyX), .done(doneX), .pass(passX), .err_count(errX), .first_err_idx(firstX)
    );

    stim_check_harness #(.WIDTH(8), .NUM_VECTORS(256), .MODE(3), .SEED(16'h000F), .LATENCY(2)) u_add (
        .clk(clk), .rst(rst), .start(startA), .stim_a(aA), .stim_b(bA), .stim_valid(vA),
        .dut_y(yA), .busy(busyA), .done(doneA), .pass(passA), .err_count(errA), .first_err_idx(firstA)
    );

    stim_check_harness #(.WIDTH(8), .NUM_VECTORS(4), .MODE(0), .SEED(16'h00A5), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst), .start(startZ), .stim_a(aZ), .stim_b(bZ), .stim_valid(vZ),
        .dut_y(yZ), .busy(busyZ), .done(doneZ), .pass(passZ), .err_count(errZ), .first_err_idx(firstZ)
    );

    // One-cycle XOR datapath that can corrupt vector 2.
    always_ff @(posedge clk) begin
        yX <= (faultX && vX && (aX == 8'd2)) ? 8'h00 : (aX ^ bX);
    end

    // Two-cycle adder; the buggy variant shifts the carry into the result.
    assign sumA = {1'b0, aA} + {1'b0, bA};
    always_ff @(posedge clk) begin
        s1A <= carryBug ? sumA[8:1] : sumA[7:0];
        yA  <= s1A;
    end

    // Combinational AND datapath with per-vector bit-0 corruption.
    assign yZ = (aZ & bZ) ^ {7'd0, badVec[aZ[1:0]] & vZ};

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses start for one sampling edge; returns 1ns after that edge (t0).
    task automatic applyStimulus(input int unit);
        case (unit)
            0:       startX = 1'b1;
            1:       startA = 1'b1;
            default: startZ = 1'b1;
        endcase
        @(posedge clk);
        #1;
        startX = 1'b0;
        startA = 1'b0;
        startZ = 1'b0;
    endtask

    logic [7:0] expB [4];

    initial begin
        expB[0] = 8'hA5;
        expB[1] = 8'hA4;
        expB[2] = 8'hA7;
        expB[3] = 8'hA6;

        // Reset and quiet idle
        rst = 1'b1;
        tick(2);
        checkOutput("rst_x", {aX, bX, vX, busyX, doneX, passX, errX, firstX}, 64'd0);
        checkOutput("rst_a", {aA, bA, vA, busyA, doneA, passA, errA, firstA}, 64'd0);
        checkOutput("rst_z", {aZ, bZ, vZ, busyZ, doneZ, passZ, errZ, firstZ}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("idle_x", {aX, bX, vX, busyX, doneX, passX, errX, firstX}, 64'd0);
        end

        // Clean XOR run
        applyStimulus(0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checkOutput("clean_valid", vX, 1'b1);
            checkOutput("clean_a", aX, k);
            checkOutput("clean_b", bX, expB[k]);
            checkOutput("clean_busy", busyX, 1'b1);
        end
        tick(1);
        checkOutput("clean_t5_valid", vX, 1'b0);
        checkOutput("clean_t5_done", doneX, 1'b0);
        checkOutput("clean_t5_busy", busyX, 1'b1);
        tick(1);
        checkOutput("clean_t6_done", doneX, 1'b1);
        checkOutput("clean_t6_pass", passX, 1'b1);
        checkOutput("clean_t6_err", errX, 16'd0);
        checkOutput("clean_t6_busy", busyX, 1'b0);

        // Fault on vector 2
        faultX = 1'b1;
        applyStimulus(0);
        tick(5);
        checkOutput("fault_t5_done", doneX, 1'b0);
        tick(1);
        checkOutput("fault_done", doneX, 1'b1);
        checkOutput("fault_err", errX, 16'd1);
        checkOutput("fault_first", firstX, 16'd2);
        checkOutput("fault_pass", passX, 1'b0);
        faultX = 1'b0;

        // Reset while vector 2 is presented
        applyStimulus(0);
        tick(3);
        checkOutput("midrun_pre_b", bX, 8'hA7);
        rst = 1'b1;
        #1;
        checkOutput("midrun_async", {aX, bX, vX, busyX, doneX, passX, errX, firstX}, 64'd0);
        tick(1);
        rst = 1'b0;
        tick(3);
        checkOutput("midrun_needs_start", {vX, busyX, doneX}, 3'd0);
        applyStimulus(0);
        tick(6);
        checkOutput("midrun_rerun_done", doneX, 1'b1);
        checkOutput("midrun_rerun_pass", passX, 1'b1);
        checkOutput("midrun_rerun_err", errX, 16'd0);

        // ADD wrap over 256 vectors, latency 2
        applyStimulus(1);
        tick(256);
        checkOutput("add_v255_a", aA, 8'hFF);
        checkOutput("add_v255_b", bA, 8'hF0);
        tick(2);
        checkOutput("add_t258_done", doneA, 1'b0);
        tick(1);
        checkOutput("add_done", doneA, 1'b1);
        checkOutput("add_pass", passA, 1'b1);
        checkOutput("add_err", errA, 16'd0);

        carryBug = 1'b1;
        applyStimulus(1);
        tick(259);
        checkOutput("carry_done", doneA, 1'b1);
        checkOutput("carry_err_nonzero", (errA != 16'd0), 1'b1);
        checkOutput("carry_first", firstA, 16'd0);
        checkOutput("carry_pass", passA, 1'b0);
        carryBug = 1'b0;

        // Latency 0 with start held: faults on vectors 1 and 3, then only 3
        badVec = 4'b1010;
        startZ = 1'b1;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checkOutput("lat0_a", aZ, k);
            checkOutput("lat0_busy", busyZ, 1'b1);
        end
        tick(1);
        checkOutput("lat0_r1_done", doneZ, 1'b1);
        checkOutput("lat0_r1_err", errZ, 16'd2);
        checkOutput("lat0_r1_first", firstZ, 16'd1);
        checkOutput("lat0_r1_pass", passZ, 1'b0);
        badVec = 4'b1000;
        tick(1);
        checkOutput("lat0_restart_done", doneZ, 1'b0);
        checkOutput("lat0_restart_err", errZ, 16'd0);
        checkOutput("lat0_restart_busy", busyZ, 1'b1);
        checkOutput("lat0_restart_a", aZ, 8'd0);
        startZ = 1'b0;
        tick(4);
        checkOutput("lat0_r2_done", doneZ, 1'b1);
        checkOutput("lat0_r2_err", errZ, 16'd1);
        checkOutput("lat0_r2_first", firstZ, 16'd3);
        checkOutput("lat0_r2_pass", passZ, 1'b0);
        tick(2);
        checkOutput("lat0_hold_done", {doneZ, busyZ, vZ}, 3'b100);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/stim_check_harness.md
# stim_check_harness

Parametrised, self-checking stimulus generator and response checker for two-input, one-output datapath DUTs. It sits in a block's testbench between the clock/reset generator and the DUT instance. It replaces hand-written stimulus with a deterministic vector sequence, a latency-matched expected-value pipeline, error counting and a pass/done summary. It is synthesisable, so the same harness also serves as an on-chip BIST wrapper.

## Interface
Parameters:
- `WIDTH`, default 8: data width of `stim_a`, `stim_b` and `dut_y`. Legal range is 1..16.
- `NUM_VECTORS`, default 16: vectors per run. Legal range is 1..65535.
- `MODE`, default 2: expected function. 0 = AND, 1 = OR, 2 = XOR, 3 = ADD modulo 2^WIDTH.
- `SEED`, default 8'hA5: constant XORed into `b`. Truncated or zero-extended to `WIDTH`.
- `LATENCY`, default 1: DUT latency in cycles, from stimulus to `dut_y`. Legal range is 0..8.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begins a run. Sampled only in IDLE or DONE.
- `stim_a`, out, WIDTH: operand a to the DUT.
- `stim_b`, out, WIDTH: operand b to the DUT.
- `stim_valid`, out, 1: the current `stim_a`/`stim_b` is a live vector.
- `dut_y`, in, WIDTH: DUT result.
- `busy`, out, 1: high in RUN or DRAIN.
- `done`, out, 1: high in DONE.
- `pass`, out, 1: `done` and `err_count == 0`.
- `err_count`, out, 16: count of mismatches. Saturates at 16'hFFFF.
- `first_err_idx`, out, 16: vector index of the first mismatch. Meaningful only when `err_count != 0`.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
  - IDLE to RUN on `start`.
  - RUN to DRAIN after vector index NUM_VECTORS-1 is issued. If LATENCY = 0, go directly to DONE instead.
  - DRAIN to DONE after LATENCY cycles.
  - DONE to RUN on `start`. Entering RUN clears `err_count`, `first_err_idx` and the vector index.
- `start` is ignored in RUN and DRAIN.
- Vector k, for k = 0..NUM_VECTORS-1:
  - `stim_a` = k[WIDTH-1:0].
  - `stim_b` = k[WIDTH-1:0] ^ SEED[WIDTH-1:0].
  - Expected value = f_MODE(a, b), truncated to WIDTH bits. For ADD, the carry is discarded.
- The expected value, valid flag and index go through a LATENCY-deep shift register.
  - The delayed valid qualifies the compare: `dut_y != expected` counts as a mismatch.
  - With LATENCY = 0, the compare is against the current vector in the same cycle.
- On each mismatch, `err_count` increments, holding at 16'hFFFF once reached.
- On the first mismatch of a run, `first_err_idx` captures the delayed index.
- When `stim_valid` is low, `stim_a` and `stim_b` hold 0.
- Reset values apply immediately on `rst` assertion, including mid-run:
  - State IDLE.
  - `stim_a` = 0, `stim_b` = 0, `stim_valid` = 0.
  - `busy` = 0, `done` = 0, `pass` = 0.
  - `err_count` = 0, `first_err_idx` = 0.
  - Delay line cleared.
- After reset, a new `start` is required.

## Timing
- Let `start` be sampled at edge t0. Vector k is registered and presented from edge t0+1+k. `stim_valid` is high for exactly NUM_VECTORS consecutive cycles.
- The compare for vector k occurs in the cycle beginning at edge t0+1+k+LATENCY.
- `done` and `pass` rise at edge t0+1+NUM_VECTORS+LATENCY. `busy` falls on the same edge.
- `busy` rises at edge t0+1.
- All outputs are registered. No combinational path exists from `dut_y` or `start` to any output.
- A back-to-back restart (`start` held in DONE) begins the next run one cycle after `done`. `done` deasserts at edge t0+1.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `start` = 0. All outputs are 0 and remain 0 for 10 further cycles.
- **Clean run:** WIDTH=8, NUM_VECTORS=4, MODE=XOR, SEED=8'hA5, LATENCY=1, correct 1-cycle DUT model.
  - `stim_b` sequence is A5, A4, A7, A6.
  - `dut_y` is A5 on every compare.
  - `done` = 1 at t0+6, `pass` = 1, `err_count` = 0.
- **Fault injection:** same setup, with the model forcing `dut_y` = 8'h00 for vector 2 only. Result is `err_count` = 1, `first_err_idx` = 2, `pass` = 0, `done` at t0+6.
- **ADD wrap:** MODE=ADD, SEED=8'h0F, NUM_VECTORS=256, LATENCY=2, correct model.
  - Vector 255 gives a = FF, b = F0, expected = EF.
  - `pass` = 1 at t0+259.
  - A model that keeps the carry (output 1EF truncated differently) gives `err_count` != 0.
- **Reset mid-run:** assert `rst` while vector 2 is presented.
  - All outputs drop to reset values asynchronously, before the next edge.
  - A later `start` completes a full clean run with `pass` = 1.
- **LATENCY=0 and restart:**
  - Hold `start` high throughout the run. It is ignored in RUN.
  - From DONE, the held `start` restarts: `err_count` clears and `done` falls at the next edge.
  - A second run with a faulty model ends with fresh counts, not accumulated ones.
